result_flag_fifo: RTL and testbench
===================================

Name: result_flag_fifo

Overview:
- Parametrised successor to the single-stage ALU result/flag register.
- Buffers up to DEPTH ALU results (2N bits) with their FLAGS-bit flag vectors in a first-word-fall-through FIFO.
- Uses a valid/ready handshake on both sides and keeps a sticky (accumulated) flag register.
- Sits between the ALU datapath and the display/consumer logic so back-pressure never loses a result silently.

Parameters:
- N, 4, ALU operand width; stored result width is 2*N.
- DEPTH, 4, number of buffered entries; power of two, minimum 2.
- FLAGS, 4, flag vector width (e.g. N, Z, C, V).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer presents result_in/flags_in.
- in_ready  out  1  FIFO can accept an entry; equals not full, registered.
- result_in  in  2*N  ALU result.
- flags_in  in  FLAGS  ALU flags for result_in.
- out_valid  out  1  head entry available; equals not empty.
- out_ready  in  1  consumer takes the head entry.
- result_out  out  2*N  head result; 0 when empty.
- flags_out  out  FLAGS  head flags; 0 when empty.
- count  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.
- sticky_flags  out  FLAGS  bitwise OR of the flags of every accepted entry since the last clear or reset.
- clr_sticky  in  1  synchronous clear of sticky_flags.
- drop  out  1  one-cycle pulse: in_valid was high while in_ready was low in the previous cycle.

Behaviour:
- Reset (rst=0, asynchronous): pointers and count = 0; in_ready = 1; out_valid = 0; result_out, flags_out, sticky_flags = 0; drop = 0. Storage contents need no reset.
- Release is synchronous to clk; the first push is possible on the first rising edge with rst=1.
- push = in_valid & in_ready; pop = out_valid & out_ready. Both are evaluated on the same edge.
- Latency: a push into an empty FIFO makes out_valid = 1 and drives the data on result_out/flags_out after that edge (1 cycle). There is no same-cycle bypass.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Full (count = DEPTH): in_ready = 0. Push is refused even if a pop occurs in the same cycle, so in_ready has no combinational path from out_ready. drop asserts the next cycle if in_valid was high.
- Empty (count = 0): out_ready is ignored. result_out and flags_out are forced to 0.
- Pointer wrap-around: pointers are log2(DEPTH) bits and wrap naturally; full/empty are decoded from count.
- Output path: result_out and flags_out come from storage[rd_ptr] muxed with out_valid. Storage is written on push.
- Sticky flags:
  - On push, sticky_flags |= flags_in.
  - On clr_sticky, sticky_flags = 0.
  - clr_sticky together with push: sticky_flags = flags_in (clear first, then accumulate the new entry).
- Reset asserted mid-operation: all state returns immediately to the reset values above; buffered entries are discarded.
- Width: no arithmetic on data; count width is $clog2(DEPTH)+1 so that DEPTH itself is representable.

Decomposition:
- Package alu_buf_pkg:
  - default localparams N_DEF=4, DEPTH_DEF=4, FLAGS_DEF=4;
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - typedef struct packed entry_t {result, flags}, parameterised by width through the module.
- Optional sub-module fifo_ptr_ctrl: owns wr_ptr, rd_ptr, count, in_ready, out_valid and drop, with no data.
- result_flag_fifo instantiates fifo_ptr_ctrl and holds the storage array and the sticky register.

Test Plan:
- Reset then idle, rst=0 for 2 cycles then 1 -> count=0, in_ready=1, out_valid=0, result_out=0, sticky_flags=0.
- Push 0x2D/flags 0b0010 into empty with out_ready=0 -> next cycle out_valid=1, result_out=0x2D, flags_out=0b0010, count=1, sticky_flags=0b0010.
- Push 5 entries 0x01..0x05 with out_ready=0 (DEPTH=4) -> count=4, in_ready=0, fifth refused, drop pulses one cycle; then pop 4 entries -> order 0x01..0x04, count=0.
- With count=2, hold in_valid=1 and out_ready=1 for 6 cycles -> count stays 2, outputs appear in FIFO order, no drop.
- Flags 0b1000 then 0b0001 pushed -> sticky=0b1001; clr_sticky together with a push of flags 0b0100 -> sticky=0b0100.
- Fill 3 entries, assert rst=0 asynchronously between edges -> out_valid, count and sticky_flags go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/alu_buf_pkg.sv
// Shared constants and types for the ALU result/flag buffer.
package alu_buf_pkg;

  localparam int N_DEF     = 4;
  localparam int DEPTH_DEF = 4;
  localparam int FLAGS_DEF = 4;

  // Bit positions inside the flag vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Entry layout at the default widths. Modules build their own copy at their widths.
  typedef struct packed {
    logic [2*N_DEF-1:0] result;
    logic [FLAGS_DEF-1:0] flags;
  } entry_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and handshake control for the result/flag FIFO (no data).
module fifo_ptr_ctrl
  import alu_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          out_ready,
  output logic          push,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output logic          in_ready,
  output logic          out_valid,
  output logic          drop
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic          pop;
  logic [CW-1:0] count_nx;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nx = count;
    if (push && !pop)
      count_nx = count + CW'(1);
    else if (!push && pop)
      count_nx = count - CW'(1);
  end

  // Pointers and flags; in_ready/out_valid are decoded from the next count so
  // in_ready never depends combinationally on out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nx;
      in_ready  <= (count_nx != FULL);
      out_valid <= (count_nx != '0);
      drop      <= in_valid & ~in_ready;
    end
  end

endmodule

// File: rtl/result_flag_fifo.sv
// First-word-fall-through FIFO of ALU results and flags with a sticky flag register.
module result_flag_fifo
  import alu_buf_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int FLAGS = FLAGS_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*N-1:0]             result_in,
  input  logic [FLAGS-1:0]           flags_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*N-1:0]             result_out,
  output logic [FLAGS-1:0]           flags_out,
  output logic [$clog2(DEPTH):0]     count,
  output logic [FLAGS-1:0]           sticky_flags,
  input  logic                       clr_sticky,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2*N-1:0]   result;
    logic [FLAGS-1:0] flags;
  } fifo_entry_t;

  fifo_entry_t       mem [DEPTH];
  fifo_entry_t       head;
  logic              push;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .push      (push),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .drop      (drop)
  );

  // Storage is written on push only; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{result: result_in, flags: flags_in};
  end

  // Head entry, forced to zero whenever the FIFO is empty.
  always_comb begin
    head       = mem[rd_ptr];
    result_out = out_valid ? head.result : '0;
    flags_out  = out_valid ? head.flags  : '0;
  end

  // Sticky flags: clear takes effect first, then the pushed entry accumulates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      sticky_flags <= '0;
    else if (clr_sticky)
      sticky_flags <= push ? flags_in : '0;
    else if (push)
      sticky_flags <= sticky_flags | flags_in;
  end

endmodule

// File: tb/tb_result_flag_fifo.sv
// Directed self-checking bench for result_flag_fifo (N=4, DEPTH=4, FLAGS=4).
module tb_result_flag_fifo;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] result_in;
  logic [3:0] flags_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result_out;
  logic [3:0] flags_out;
  logic [2:0] count;
  logic [3:0] sticky_flags;
  logic       clr_sticky;
  logic       drop;

  int n_cmp;
  int n_bad;

  result_flag_fifo #(.N(4), .DEPTH(4), .FLAGS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .result_in    (result_in),
    .flags_in     (flags_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result_out   (result_out),
    .flags_out    (flags_out),
    .count        (count),
    .sticky_flags (sticky_flags),
    .clr_sticky   (clr_sticky),
    .drop         (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    result_in = '0;
    flags_in = '0;
    clr_sticky = 1'b0;

    // Reset then idle
    tick(); tick();
    rst = 1'b1;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", 32'(result_out), 0);
    chk("rst_sticky", 32'(sticky_flags), 0);
    chk("rst_drop", 32'(drop), 0);

    // Empty: out_ready ignored
    out_ready = 1'b1;
    tick();
    chk("empty_pop_count", 32'(count), 0);
    out_ready = 1'b0;

    // Single push into empty
    in_valid = 1'b1; result_in = 8'h2D; flags_in = 4'b0010;
    tick();
    in_valid = 1'b0;
    chk("p1_out_valid", 32'(out_valid), 1);
    chk("p1_result", 32'(result_out), 32'h2D);
    chk("p1_flags", 32'(flags_out), 32'b0010);
    chk("p1_count", 32'(count), 1);
    chk("p1_sticky", 32'(sticky_flags), 32'b0010);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("p1_pop_count", 32'(count), 0);
    chk("p1_pop_result0", 32'(result_out), 0);
    chk("p1_pop_flags0", 32'(flags_out), 0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    chk("clr_sticky", 32'(sticky_flags), 0);

    // Fill past full
    flags_in = 4'b0000;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1; result_in = 8'(i);
      tick();
      if (i <= 4) chk($sformatf("fill_count_%0d", i), 32'(count), 32'(i));
      if (i < 4)  chk($sformatf("fill_ready_%0d", i), 32'(in_ready), 1);
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_drop", 32'(drop), 1);

    // Pop while full and still pushing: push refused
    result_in = 8'h55;
    out_ready = 1'b1;
    chk("drain_head_1", 32'(result_out), 1);
    tick();
    in_valid = 1'b0;
    chk("fullpop_count", 32'(count), 3);
    chk("fullpop_drop", 32'(drop), 1);
    chk("fullpop_in_ready", 32'(in_ready), 1);
    for (int i = 2; i <= 4; i++) begin
      chk($sformatf("drain_head_%0d", i), 32'(result_out), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_count", 32'(count), 0);
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_drop", 32'(drop), 0);

    // Steady state at count=2
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; result_in = 8'(8'h10 + i);
      tick();
    end
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; out_ready = 1'b1; result_in = 8'(8'h12 + k);
      chk($sformatf("ss_head_%0d", k), 32'(result_out), 32'(8'h10 + k));
      tick();
      chk($sformatf("ss_count_%0d", k), 32'(count), 2);
      chk($sformatf("ss_drop_%0d", k), 32'(drop), 0);
    end
    in_valid = 1'b0;
    chk("ss_tail_a", 32'(result_out), 32'h16);
    tick();
    chk("ss_tail_b", 32'(result_out), 32'h17);
    tick();
    out_ready = 1'b0;
    chk("ss_empty", 32'(count), 0);

    // Sticky accumulation and clear-with-push
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    in_valid = 1'b1; result_in = 8'hA1; flags_in = 4'b1000;
    tick();
    result_in = 8'hA2; flags_in = 4'b0001;
    tick();
    chk("sticky_or", 32'(sticky_flags), 32'b1001);
    result_in = 8'hA3; flags_in = 4'b0100; clr_sticky = 1'b1;
    tick();
    in_valid = 1'b0; clr_sticky = 1'b0; flags_in = '0;
    chk("sticky_clr_push", 32'(sticky_flags), 32'b0100);
    chk("three_count", 32'(count), 3);
    chk("three_head", 32'(result_out), 32'hA1);
    chk("three_head_flags", 32'(flags_out), 32'b1000);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_sticky", 32'(sticky_flags), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    chk("arst_result", 32'(result_out), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_count", 32'(count), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
